alu_issuer: RTL and testbench

- Initiator side of the ALU operand interface. Accepts operation requests over a valid/ready handshake, registers them, and drives `oc`/`a`/`b` into a combinational ALU instance.
- Samples the ALU result after one settle cycle and returns it over a second valid/ready handshake.
- Flags division by zero and keeps operation and error counters.
- Sits between the control/datapath sequencer and the ALU.

---
 rtl/alu_issuer.sv | 153 +++++++++++++++
 tb/tb_alu_issuer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// alu_issuer: initiator side of the ALU operand interface.
// Registers a request into the ALU operand flops, waits one cycle for the
// combinational ALU to settle, captures the result and holds it on a
// valid/ready response port. Division by zero is flagged and its result is
// forced to all-ones. Completed responses and error responses are counted.
module alu_issuer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_oc,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_f,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [2:0] OC_DIV = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            alu_oc_q, alu_oc_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [DATA_WIDTH-1:0] rsp_f_q, rsp_f_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  req_fire;
  logic                  div_by_zero;

  // A new request can be taken when idle, or in the same edge the current
  // response is consumed (back-to-back).
  assign req_ready   = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign req_fire    = req_valid && req_ready;
  assign div_by_zero = (alu_oc_q == OC_DIV) && (alu_b_q == '0);

  // Next-state, operand, result and counter computation.
  always_comb begin
    state_d     = state_q;
    alu_oc_d    = alu_oc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_f_d     = rsp_f_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          alu_oc_d = req_oc;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (div_by_zero) begin
          rsp_f_d   = '1;
          rsp_err_d = 1'b1;
        end else begin
          rsp_f_d   = alu_f;
          rsp_err_d = 1'b0;
        end
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_WIDTH'(1);
          if (rsp_err_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_WIDTH'(1);
          end
          rsp_valid_d = 1'b0;
          if (req_fire) begin
            alu_oc_d = req_oc;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            state_d  = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; synchronous active-low reset drops any
  // in-flight operation without touching the counters' history beyond zeroing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_oc_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_f_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      alu_oc_q    <= alu_oc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_f_q     <= rsp_f_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: directed steps with a response
// scoreboard. A second instance with 4-bit counters shares the stimulus to
// exercise counter wrap.
module tb_alu_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_oc;
  logic [15:0] req_a, req_b;
  logic [2:0]  alu_oc;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_f;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  op_count, err_count;

  logic        req_ready4;
  logic [2:0]  alu_oc4;
  logic [15:0] alu_a4, alu_b4, alu_f4;
  logic        rsp_valid4;
  logic [15:0] rsp_f4;
  logic        rsp_err4;
  logic        busy4;
  logic [3:0]  op_count4, err_count4;

  typedef struct packed {
    logic [15:0] f;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] cur_f;
  logic        cur_err;
  logic [7:0]  m_ops;
  logic [7:0]  m_errs;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          rf;

  always #5 clk = ~clk;

  // Combinational ALU stand-in; its own divide-by-zero value is deliberately
  // not all-ones so the issuer's override is visible.
  function automatic logic [15:0] alu_model(input logic [2:0] oc, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] p;
    case (oc)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin p = a * b; return p[15:0]; end
      3'd3: return (b == 16'd0) ? 16'h1234 : a / b;
      3'd4: return ~a;
      3'd5: return a ^ b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Expected response as seen on the issuer's response port.
  function automatic logic [15:0] ref_f(input logic [2:0] oc, input logic [15:0] a,
                                        input logic [15:0] b);
    if (oc == 3'd3 && b == 16'd0) return 16'hFFFF;
    return alu_model(oc, a, b);
  endfunction

  assign alu_f  = alu_model(alu_oc, alu_a, alu_b);
  assign alu_f4 = alu_model(alu_oc4, alu_a4, alu_b4);

  alu_issuer #(.DATA_WIDTH(16), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_oc(req_oc), .req_a(req_a), .req_b(req_b),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  alu_issuer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready4),
    .req_oc(req_oc), .req_a(req_a), .req_b(req_b),
    .alu_oc(alu_oc4), .alu_a(alu_a4), .alu_b(alu_b4), .alu_f(alu_f4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_f(rsp_f4), .rsp_err(rsp_err4),
    .busy(busy4), .op_count(op_count4), .err_count(err_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Evaluate handshakes just before the next edge, update the scoreboard,
  // then advance to 1 time unit after that edge.
  task automatic tick(output bit req_fired);
    bit sf;
    exp_t e;
    #1;
    req_fired = req_valid && req_ready && rst_n;
    sf        = rsp_valid && rsp_ready && rst_n;
    if (sf) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_rsp: observed=rsp_f 0x%0h expected=no response", rsp_f);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_f", {16'd0, rsp_f}, {16'd0, e.f});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        m_ops = m_ops + 8'd1;
        if (e.err && m_errs != 8'hFF) m_errs = m_errs + 8'd1;
      end
    end
    if (req_fired) begin
      sb.push_back('{f: cur_f, err: cur_err});
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_req(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] f, input logic err);
    req_oc    = oc;
    req_a     = a;
    req_b     = b;
    cur_f     = f;
    cur_err   = err;
    req_valid = 1'b1;
  endtask

  task automatic accept_req(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] f, input logic err);
    bit got;
    got = 1'b0;
    drive_req(oc, a, b, f, err);
    for (int i = 0; i < 20 && !got; i++) begin
      tick(got);
    end
    chk("accept", {31'd0, got}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] oc, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] f, input logic err);
    accept_req(oc, a, b, f, err);
    chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    tick(rf);
    chk({tag, "_resp_valid"}, {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick(rf);
    rsp_ready = 1'b0;
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    chk({tag, "_op_count"}, {24'd0, op_count}, {24'd0, m_ops});
    chk({tag, "_err_count"}, {24'd0, err_count}, {24'd0, m_errs});
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic stream(input int n);
    int          k;
    int          prev;
    logic [2:0]  oc;
    logic [15:0] a, b;
    k = 0;
    prev = 0;
    rsp_ready = 1'b1;
    oc = 3'd0; a = 16'($urandom); b = 16'($urandom);
    drive_req(oc, a, b, ref_f(oc, a, b), 1'b0);
    for (int c = 0; c < 4 * n + 10 && k < n; c++) begin
      tick(rf);
      if (rf) begin
        if (k > 0) chk("accept_gap", acc_cyc - prev, 32'd2);
        prev = acc_cyc;
        k++;
        if (k < n) begin
          oc = 3'(k);
          a  = 16'($urandom);
          b  = (k % 5 == 3) ? 16'd0 : 16'($urandom);
          drive_req(oc, a, b, ref_f(oc, a, b), (oc == 3'd3) && (b == 16'd0));
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("stream_accepts", k, n);
    for (int c = 0; c < 10 && sb.size() > 0; c++) tick(rf);
    rsp_ready = 1'b0;
    chk("stream_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_oc = '0; req_a = '0; req_b = '0;
    cur_f = '0; cur_err = 1'b0; m_ops = '0; m_errs = '0;

    // Reset for two cycles, then check reset values.
    tick(rf);
    tick(rf);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_f", {16'd0, rsp_f}, 32'd0);
    chk("rst_alu_oc", {29'd0, alu_oc}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    // Basic ADD and wrap/truncation cases.
    do_op("add", 3'd0, 16'h0005, 16'h0003, 16'h0008, 1'b0);
    do_op("add_wrap", 3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);
    do_op("mul_trunc", 3'd2, 16'h0100, 16'h0100, 16'h0000, 1'b0);
    do_op("sub_wrap", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);

    // Divide by zero then a normal divide.
    do_op("div0", 3'd3, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    chk("div0_err_count", {24'd0, err_count}, 32'd1);
    do_op("div", 3'd3, 16'h0064, 16'h0007, 16'h000E, 1'b0);
    chk("div_err_count", {24'd0, err_count}, 32'd1);

    // Back-pressure with a second request pending.
    accept_req(3'd5, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0);
    tick(rf);
    drive_req(3'd7, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(rf);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_f", {16'd0, rsp_f}, 32'h0FF0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    tick(rf);
    chk("bp_same_edge_accept", {31'd0, rf}, 32'd1);
    req_valid = 1'b0;
    chk("bp_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_alu_oc", {29'd0, alu_oc}, 32'd7);
    tick(rf);
    chk("bp_resp_valid", {31'd0, rsp_valid}, 32'd1);
    tick(rf);
    rsp_ready = 1'b0;
    chk("bp_sb_empty", sb.size(), 32'd0);
    chk("bp_op_count", {24'd0, op_count}, {24'd0, m_ops});

    // Reset during EXEC drops the operation.
    accept_req(3'd4, 16'h00FF, 16'h0000, 16'hFF00, 1'b0);
    chk("mid_in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick(rf);
    sb.delete();
    m_ops = '0;
    m_errs = '0;
    rst_n = 1'b1;
    #1;
    chk("mid_alu_a", {16'd0, alu_a}, 32'd0);
    chk("mid_op_count", {24'd0, op_count}, 32'd0);
    chk("mid_err_count", {24'd0, err_count}, 32'd0);
    chk("mid_op_count4", {28'd0, op_count4}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(rf);
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_op("not", 3'd4, 16'h00FF, 16'h0000, 16'hFF00, 1'b0);

    // Back-to-back streams; 4-bit counter instance wraps.
    stream(10);
    chk("stream10_op_count", {24'd0, op_count}, {24'd0, m_ops});
    chk("stream10_op_count4", {28'd0, op_count4}, {28'd0, m_ops[3:0]});
    chk("stream10_err_count", {24'd0, err_count}, {24'd0, m_errs});
    stream(10);
    chk("stream20_op_count", {24'd0, op_count}, {24'd0, m_ops});
    chk("stream20_op_count4", {28'd0, op_count4}, {28'd0, m_ops[3:0]});
    chk("stream20_op_count4_val", {28'd0, op_count4}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
